// File: rtl/knight_anim_seq.sv
// Knight animation sequencer: turns per-frame player status, facing and life into a
// registered sprite animation ID / frame index plus mirror, visibility and attack pulses.
module knight_anim_seq #(
  parameter int unsigned IDLE_TICKS = 8,
  parameter int unsigned WALK_TICKS = 4,
  parameter int unsigned JUMP_TICKS = 4,
  parameter int unsigned FALL_TICKS = 6,
  parameter int unsigned ATK_TICKS  = 3,
  parameter int unsigned DEAD_TICKS = 8,
  parameter int unsigned INVULN_LEN = 48
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [3:0] Player_Status,
  input  logic [3:0] Player_Life,
  input  logic       Inverse,
  output logic [2:0] Anim_ID,
  output logic [2:0] Frame_Index,
  output logic [5:0] Frame_Addr,
  output logic       Mirror,
  output logic       Visible,
  output logic       Attack_Strike,
  output logic       Anim_Done
);

  localparam int unsigned InvW = (INVULN_LEN < 8) ? 3 : $clog2(INVULN_LEN + 1);

  typedef enum logic [2:0] {
    AnimIdle   = 3'd0,
    AnimWalk   = 3'd1,
    AnimJump   = 3'd2,
    AnimFall   = 3'd3,
    AnimAttack = 3'd4,
    AnimDead   = 3'd5
  } anim_e;

  anim_e            anim_q, anim_d, req;
  logic [2:0]       frame_q, frame_d;
  logic [3:0]       tick_q, tick_d;
  logic [3:0]       prev_life_q;
  logic [InvW-1:0]  inv_q, inv_d;
  logic             mirror_q, mirror_d;
  logic             visible_q, visible_d;
  logic             strike_q, strike_d;
  logic             done_q, done_d;
  logic             tick_end, at_last, hit;

  function automatic logic [3:0] tick_last(anim_e a);
    case (a)
      AnimIdle:   return 4'(IDLE_TICKS - 1);
      AnimWalk:   return 4'(WALK_TICKS - 1);
      AnimJump:   return 4'(JUMP_TICKS - 1);
      AnimFall:   return 4'(FALL_TICKS - 1);
      AnimAttack: return 4'(ATK_TICKS - 1);
      default:    return 4'(DEAD_TICKS - 1);
    endcase
  endfunction

  function automatic logic [2:0] frame_last(anim_e a);
    case (a)
      AnimIdle:   return 3'd3;
      AnimWalk:   return 3'd5;
      AnimJump:   return 3'd2;
      AnimFall:   return 3'd1;
      AnimAttack: return 3'd4;
      default:    return 3'd3;
    endcase
  endfunction

  function automatic logic is_hold(anim_e a);
    return (a == AnimJump) || (a == AnimDead);
  endfunction

  always_comb begin
    case (Player_Status)
      4'd1:    req = AnimWalk;
      4'd2:    req = AnimJump;
      4'd3:    req = AnimFall;
      4'd4:    req = AnimAttack;
      default: req = AnimIdle;
    endcase
    if (Player_Life == 4'd0) req = AnimDead;

    anim_d   = anim_q;
    frame_d  = frame_q;
    tick_d   = tick_q;
    strike_d = 1'b0;
    done_d   = 1'b0;
    tick_end = (tick_q == tick_last(anim_q));
    at_last  = (frame_q == frame_last(anim_q));

    if (req == AnimDead && anim_q != AnimDead) begin
      // Death preempts everything, including a locked attack.
      anim_d  = AnimDead;
      frame_d = 3'd0;
      tick_d  = 4'd0;
    end else if (anim_q == AnimAttack) begin
      if (tick_end) begin
        tick_d = 4'd0;
        if (at_last) begin
          done_d  = 1'b1;
          anim_d  = req;
          frame_d = 3'd0;
        end else begin
          frame_d  = frame_q + 3'd1;
          strike_d = (frame_q == 3'd1);
        end
      end else begin
        tick_d = tick_q + 4'd1;
      end
    end else if (anim_q != AnimDead && req != anim_q) begin
      anim_d  = req;
      frame_d = 3'd0;
      tick_d  = 4'd0;
    end else if (is_hold(anim_q) && at_last) begin
      tick_d = 4'd0;
    end else if (tick_end) begin
      tick_d  = 4'd0;
      frame_d = at_last ? 3'd0 : frame_q + 3'd1;
    end else begin
      tick_d = tick_q + 4'd1;
    end

    // Facing is frozen for the duration of an attack; a restarted attack re-latches it.
    mirror_d = mirror_q;
    if (anim_d == AnimDead) begin
      mirror_d = 1'b0;
    end else if (anim_d != AnimAttack || anim_q != AnimAttack || done_d) begin
      mirror_d = Inverse;
    end

    hit = (Player_Life < prev_life_q) && (Player_Life != 4'd0);
    if (hit) begin
      inv_d = InvW'(INVULN_LEN);
    end else if (inv_q != '0) begin
      inv_d = inv_q - InvW'(1);
    end else begin
      inv_d = '0;
    end
    visible_d = (anim_d == AnimDead) || (inv_d == '0) || !inv_d[2];
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      anim_q      <= AnimIdle;
      frame_q     <= 3'd0;
      tick_q      <= 4'd0;
      prev_life_q <= 4'd0;
      inv_q       <= '0;
      mirror_q    <= 1'b0;
      visible_q   <= 1'b1;
      strike_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      anim_q      <= anim_d;
      frame_q     <= frame_d;
      tick_q      <= tick_d;
      prev_life_q <= Player_Life;
      inv_q       <= inv_d;
      mirror_q    <= mirror_d;
      visible_q   <= visible_d;
      strike_q    <= strike_d;
      done_q      <= done_d;
    end
  end

  assign Anim_ID       = anim_q;
  assign Frame_Index   = frame_q;
  assign Frame_Addr    = {anim_q, frame_q};
  assign Mirror        = mirror_q;
  assign Visible       = visible_q;
  assign Attack_Strike = strike_q;
  assign Anim_Done     = done_q;

endmodule

// File: tb/tb_knight_anim_seq.sv
// Bench for knight_anim_seq: fixed vector table, hand-written corner sequences and a
// randomized run against a frame/tick reference model.
module tb_knight_anim_seq;

  logic       frame_clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] Player_Status = 4'd0;
  logic [3:0] Player_Life = 4'd0;
  logic       Inverse = 1'b0;
  logic [2:0] Anim_ID, Frame_Index;
  logic [5:0] Frame_Addr;
  logic       Mirror, Visible, Attack_Strike, Anim_Done;

  int n_cmp = 0;
  int n_bad = 0;

  knight_anim_seq dut (
    .frame_clk    (frame_clk),
    .Reset_n      (Reset_n),
    .Player_Status(Player_Status),
    .Player_Life  (Player_Life),
    .Inverse      (Inverse),
    .Anim_ID      (Anim_ID),
    .Frame_Index  (Frame_Index),
    .Frame_Addr   (Frame_Addr),
    .Mirror       (Mirror),
    .Visible      (Visible),
    .Attack_Strike(Attack_Strike),
    .Anim_Done    (Anim_Done)
  );

  always #5 frame_clk = ~frame_clk;

  // Reference model: animation table as plain arrays, counters as integers.
  int nfr[6]  = '{4, 6, 3, 2, 5, 4};
  int tks[6]  = '{8, 4, 4, 6, 3, 8};
  bit hold[6] = '{0, 0, 1, 0, 0, 1};
  int m_anim, m_frame, m_tick, m_rem, m_prev;
  bit m_mirror, m_vis, m_strike, m_done;

  typedef struct {
    logic [3:0] st;
    logic       inv;
    int         anim;
    int         frame;
    bit         strike;
    bit         done;
    bit         mirror;
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_anim = 0; m_frame = 0; m_tick = 0; m_rem = 0; m_prev = 0;
    m_mirror = 0; m_vis = 1; m_strike = 0; m_done = 0;
  endtask

  task automatic model_step(input logic [3:0] st, input logic [3:0] life, input logic inv);
    int req;
    bit entered;
    req = (life == 0) ? 5 : ((st <= 4) ? int'(st) : 0);
    m_strike = 0; m_done = 0; entered = 0;
    if (req == 5 && m_anim != 5) begin
      m_anim = 5; m_frame = 0; m_tick = 0;
    end else if (m_anim == 4) begin
      m_tick++;
      if (m_tick == tks[4]) begin
        m_tick = 0;
        if (m_frame == nfr[4] - 1) begin
          m_done = 1; m_anim = req; m_frame = 0; entered = 1;
        end else begin
          m_frame++;
          m_strike = (m_frame == 2);
        end
      end
    end else if (m_anim != 5 && req != m_anim) begin
      m_anim = req; m_frame = 0; m_tick = 0; entered = 1;
    end else if (hold[m_anim] && m_frame == nfr[m_anim] - 1) begin
      m_tick = 0;
    end else begin
      m_tick++;
      if (m_tick == tks[m_anim]) begin
        m_tick = 0;
        m_frame = (m_frame + 1) % nfr[m_anim];
      end
    end
    if (m_anim == 5) m_mirror = 0;
    else if (m_anim != 4 || entered) m_mirror = inv;
    if (int'(life) < m_prev && life != 0) m_rem = 48;
    else if (m_rem > 0) m_rem--;
    m_prev = int'(life);
    m_vis = (m_anim == 5) || (m_rem == 0) || ((m_rem / 4) % 2 == 0);
  endtask

  task automatic step(input logic [3:0] st, input logic [3:0] life, input logic inv);
    Player_Status = st; Player_Life = life; Inverse = inv;
    @(posedge frame_clk);
    #1;
    model_step(st, life, inv);
  endtask

  task automatic compare_model(input string tag);
    check({tag, " anim"},   int'(Anim_ID),       m_anim);
    check({tag, " frame"},  int'(Frame_Index),   m_frame);
    check({tag, " addr"},   int'(Frame_Addr),    m_anim * 8 + m_frame);
    check({tag, " mirror"}, int'(Mirror),        int'(m_mirror));
    check({tag, " vis"},    int'(Visible),       int'(m_vis));
    check({tag, " strike"}, int'(Attack_Strike), int'(m_strike));
    check({tag, " done"},   int'(Anim_Done),     int'(m_done));
  endtask

  // Called at posedge+1; pulses reset well clear of both clock edges.
  task automatic do_reset();
    Reset_n = 1'b0;
    #3;
    model_reset();
    Reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] st, life;
    logic       inv;
    int         dead_edges;

    tbl[0]  = '{4'd4, 1'b0, 4, 0, 0, 0, 0};
    tbl[1]  = '{4'd0, 1'b0, 4, 0, 0, 0, 0};
    tbl[2]  = '{4'd0, 1'b0, 4, 0, 0, 0, 0};
    tbl[3]  = '{4'd0, 1'b0, 4, 1, 0, 0, 0};
    tbl[4]  = '{4'd0, 1'b1, 4, 1, 0, 0, 0};
    tbl[5]  = '{4'd0, 1'b1, 4, 1, 0, 0, 0};
    tbl[6]  = '{4'd0, 1'b1, 4, 2, 1, 0, 0};
    tbl[7]  = '{4'd0, 1'b1, 4, 2, 0, 0, 0};
    tbl[8]  = '{4'd0, 1'b1, 4, 2, 0, 0, 0};
    tbl[9]  = '{4'd0, 1'b1, 4, 3, 0, 0, 0};
    tbl[10] = '{4'd0, 1'b1, 4, 3, 0, 0, 0};
    tbl[11] = '{4'd0, 1'b1, 4, 3, 0, 0, 0};
    tbl[12] = '{4'd0, 1'b1, 4, 4, 0, 0, 0};
    tbl[13] = '{4'd0, 1'b1, 4, 4, 0, 0, 0};
    tbl[14] = '{4'd0, 1'b1, 4, 4, 0, 0, 0};
    tbl[15] = '{4'd0, 1'b1, 0, 0, 0, 1, 1};
    tbl[16] = '{4'd0, 1'b1, 0, 0, 0, 0, 1};

    model_reset();
    @(posedge frame_clk);
    @(posedge frame_clk);
    #1;
    check("reset anim",   int'(Anim_ID), 0);
    check("reset frame",  int'(Frame_Index), 0);
    check("reset addr",   int'(Frame_Addr), 0);
    check("reset mirror", int'(Mirror), 0);
    check("reset vis",    int'(Visible), 1);
    check("reset strike", int'(Attack_Strike), 0);
    check("reset done",   int'(Anim_Done), 0);
    Reset_n = 1'b1;

    // Single attack request with facing flipped mid-attack.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].st, 4'd2, tbl[i].inv);
      check($sformatf("tbl[%0d] anim", i),   int'(Anim_ID),       tbl[i].anim);
      check($sformatf("tbl[%0d] frame", i),  int'(Frame_Index),   tbl[i].frame);
      check($sformatf("tbl[%0d] strike", i), int'(Attack_Strike), int'(tbl[i].strike));
      check($sformatf("tbl[%0d] done", i),   int'(Anim_Done),     int'(tbl[i].done));
      check($sformatf("tbl[%0d] mirror", i), int'(Mirror),        int'(tbl[i].mirror));
      check($sformatf("tbl[%0d] vis", i),    int'(Visible),       1);
    end

    // Idle loop: frame advances every 8 edges and wraps after 4 frames.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      step(4'd0, 4'd2, 1'b0);
      check($sformatf("idle frame e%0d", k), int'(Frame_Index), (k / 8) % 4);
      check($sformatf("idle vis e%0d", k), int'(Visible), 1);
    end

    // Jump holds its last frame.
    do_reset();
    step(4'd2, 4'd2, 1'b0);
    check("jump entry anim", int'(Anim_ID), 2);
    check("jump entry frame", int'(Frame_Index), 0);
    for (int k = 1; k < 20; k++) begin
      step(4'd2, 4'd2, 1'b0);
      if (k == 7) check("jump frame e7", int'(Frame_Index), 1);
      if (k == 8) check("jump frame e8", int'(Frame_Index), 2);
    end
    check("jump hold frame", int'(Frame_Index), 2);
    check("jump hold anim", int'(Anim_ID), 2);

    // Hit during an attack, then death preempts the attack.
    do_reset();
    step(4'd0, 4'd2, 1'b1);
    step(4'd4, 4'd2, 1'b1);
    check("atk mirror latch", int'(Mirror), 1);
    step(4'd4, 4'd1, 1'b0);
    check("atk hit vis", int'(Visible), 1);
    check("atk mirror held", int'(Mirror), 1);
    step(4'd4, 4'd1, 1'b0);
    check("atk blink vis", int'(Visible), 0);
    step(4'd0, 4'd0, 1'b1);
    check("death anim", int'(Anim_ID), 5);
    check("death frame", int'(Frame_Index), 0);
    check("death mirror", int'(Mirror), 0);
    check("death vis", int'(Visible), 1);
    check("death done", int'(Anim_Done), 0);
    for (int k = 0; k < 32; k++) step(4'd1, 4'd3, 1'b1);
    check("dead sticky anim", int'(Anim_ID), 5);
    check("dead hold frame", int'(Frame_Index), 3);
    check("dead vis", int'(Visible), 1);

    // Asynchronous reset in the middle of a blink.
    do_reset();
    step(4'd0, 4'd2, 1'b0);
    step(4'd0, 4'd1, 1'b0);
    step(4'd0, 4'd1, 1'b0);
    check("blink before reset", int'(Visible), 0);
    step(4'd1, 4'd1, 1'b1);
    Reset_n = 1'b0;
    #2;
    check("async reset vis", int'(Visible), 1);
    check("async reset anim", int'(Anim_ID), 0);
    check("async reset mirror", int'(Mirror), 0);
    Reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      step(4'd0, 4'd1, 1'b0);
      compare_model("post-reset");
    end

    // Life drop straight to zero: death only, no blink.
    do_reset();
    step(4'd1, 4'd2, 1'b0);
    step(4'd1, 4'd0, 1'b0);
    check("drop0 anim", int'(Anim_ID), 5);
    check("drop0 vis", int'(Visible), 1);
    for (int k = 0; k < 6; k++) step(4'd1, 4'd0, 1'b0);
    check("drop0 vis later", int'(Visible), 1);

    // Randomized run against the reference model.
    do_reset();
    st = 4'd0; life = 4'd3; inv = 1'b0; dead_edges = 0;
    for (int n = 0; n < 4000; n++) begin
      if ((n % 500 == 499) || dead_edges > 60) begin
        do_reset();
        life = 4'd3;
        dead_edges = 0;
      end
      if ($urandom_range(0, 99) < 15)
        st = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      if ($urandom_range(0, 99) < 8) inv = ~inv;
      if ($urandom_range(0, 999) < 3) life = 4'd0;
      else if ($urandom_range(0, 99) < 2 && life > 4'd1) life = life - 4'd1;
      else if ($urandom_range(0, 99) < 1 && life < 4'd9) life = life + 4'd1;
      step(st, life, inv);
      compare_model("rand");
      if (m_anim == 5) dead_edges++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
